sn_block_loader: RTL
====================

Name: sn_block_loader

Overview:
- Upstream feeder for the even-odd merge sorting network.
- Accepts records as a valid/ready stream, `1<<W_LOG` records per beat, and gathers them into one full-width block of `1<<P_LOG` records.
- Issues the block as a single-cycle DOT/DOTEN pulse, which drives the network's DIN/DINEN directly.
- A short final block (ILAST) is padded with max-key records so the pads sort to the tail.

Parameters:
- P_LOG, 9, log2 of records per sorter block.
- W_LOG, 0, log2 of records per input beat; must satisfy W_LOG <= P_LOG.
- DATW, 64, record width in bits.
- KEYW, 32, key width; the key is the low KEYW bits of a record.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- IVALID  in  1  input beat valid.
- IREADY  out  1  loader can accept a beat.
- IDATA  in  DATW<<W_LOG  beat; record j occupies bits [DATW*(j+1)-1:DATW*j].
- ILAST  in  1  this beat ends the current block (flush).
- DOT  out  DATW<<P_LOG  assembled block; record i occupies bits [DATW*(i+1)-1:DATW*i].
- DOTEN  out  1  one-cycle strobe: DOT holds a new block.
- OCNT  out  P_LOG+1  number of real, non-pad records in DOT (1..1<<P_LOG).

Behaviour:
- Definitions:
  - NB = 1<<(P_LOG-W_LOG) beats per block.
  - Beat counter `idx` is P_LOG-W_LOG bits wide and wraps naturally.
  - Accept = IVALID && IREADY.
- Reset (RST=1 at a clock edge): DOTEN=0, DOT=0, OCNT=0, idx=0, fill buffer contents don't-care, IREADY=0.
  - IREADY=1 from the first cycle after RST deasserts.
  - Reset mid-fill discards the partial block; nothing is emitted.
- States:
  - IDLE: in reset, IREADY=0.
  - FILL: IREADY=1 continuously.
  - There is no bubble state; a full block emits with zero stall.
- Accept with idx < NB-1 and ILAST=0:
  - Beat is written into buffer slot idx, i.e. records idx<<W_LOG .. (idx<<W_LOG)+(1<<W_LOG)-1.
  - idx increments.
- Accept with idx == NB-1 (ILAST ignored):
  - DOT is registered as {IDATA, buffer slots 0..NB-2}.
  - DOTEN=1 in the next cycle; OCNT=1<<P_LOG; idx becomes 0.
- Accept with ILAST=1 and idx < NB-1:
  - DOT is registered as buffer slots 0..idx-1, IDATA at slot idx, and every slot above idx replaced by PAD = {DATW{1'b1}}.
  - DOTEN=1 next cycle; OCNT=(idx+1)<<W_LOG; idx becomes 0.
  - Stale data from earlier blocks must never appear in DOT.
- Latency: DOTEN rises exactly 1 cycle after the completing accept.
- DOT is held stable until the next DOTEN; DOTEN is never high for two consecutive cycles unless two consecutive accepts both complete blocks (possible when NB=1).
- The fill buffer and the DOT register are separate: the beat accepted in the same cycle DOTEN is high goes to slot 0 of the next block and leaves DOT untouched.
- No beat is ever lost or duplicated. IVALID=0 holds all state.
- Key 2^KEYW-1 is reserved for padding. Real records carrying that key may interleave with pads, and OCNT remains authoritative.
- IDATA/ILAST are don't-care when IVALID=0.

Decomposition:
- Shared header `sn_defs.vh`: default P_LOG/DATW/KEYW, the PAD record constant, and the record-slice index macro. These are also used by the sorter and its bench.
- One sub-module, sn_pad_mask:
  - Combinational.
  - Maps idx and ILAST to a NB-bit keep mask (thermometer: slots <= idx keep, others pad).
  - Also computes OCNT.
- Remaining RTL: buffer write generate loop, DOT merge mux, counter, strobe.

Test Plan:
All scenarios use P_LOG=3, W_LOG=1, DATW=64, KEYW=32 (NB=4, 8 records per block).
- Full block:
  - Stimulus: 4 consecutive beats with keys (8,7),(6,5),(4,3),(2,1), IVALID=1 throughout.
  - Response: DOTEN exactly 1 cycle after beat 4; DOT records 0..7 = 8,7,6,5,4,3,2,1; OCNT=8; IREADY=1 throughout.
- Back-to-back blocks:
  - Stimulus: 8 beats streamed without gaps.
  - Response: two DOTEN pulses 4 cycles apart; the second block is unaffected by the first; no stall.
- Short flush:
  - Stimulus: 2 beats (keys 5,9),(3,1) with ILAST on beat 2, after a prior full block of keys 0x10..0x17.
  - Response: DOT = 5,9,3,1 then four all-ones records (no 0x14..0x17 leftovers); OCNT=4.
- Gaps:
  - Stimulus: IVALID toggles 1,0,0,1,0,1,1.
  - Response: exactly 4 accepts; DOTEN 1 cycle after the 4th accept; DOT identical to the gap-free case.
- Reset mid-fill:
  - Stimulus: 2 beats, then RST=1 for 2 cycles, then 4 beats keys 1..8.
  - Response: no DOTEN during or after reset until the 4th new beat; DOT = 1..8; IREADY=0 while RST=1.
- ILAST on the final slot:
  - Stimulus: ILAST=1 on beat 4.
  - Response: identical to a normal full block (OCNT=8, no pads).
  - Also, in an NB=1 configuration (P_LOG=W_LOG=1), DOTEN is high on consecutive cycles for consecutive accepts.

Source files
------------

// File: rtl/sn_block_loader_pkg.sv
// ---------------------------------------------------------------------------
// sn_block_loader_pkg
// Shared definitions for the sorting-network loader and its helpers:
//   - default geometry (records per block, records per beat, record/key width)
//   - loader state encodings
//   - record-slice helper (low bit of record i in a flattened vector)
//   - beat-index width helper (stays at least 1 bit when a block is one beat)
// No ports; imported by the loader RTL and by benches that build blocks.
// ---------------------------------------------------------------------------
package sn_block_loader_pkg;

    localparam int SN_DEF_P_LOG = 9;
    localparam int SN_DEF_W_LOG = 0;
    localparam int SN_DEF_DATW  = 64;
    localparam int SN_DEF_KEYW  = 32;

    localparam logic [0:0] SN_IDLE = 1'b0;
    localparam logic [0:0] SN_FILL = 1'b1;

    // Low bit of record i in a vector of datw-wide records packed from bit 0 up.
    function automatic int sn_rec_lo(input int i, input int datw);
        return i * datw;
    endfunction

    // Width of the beat counter; a one-beat block still gets a 1-bit counter
    // so that no zero-width vectors appear.
    function automatic int sn_idx_w(input int p_log, input int w_log);
        return (p_log > w_log) ? (p_log - w_log) : 1;
    endfunction

endpackage

// File: rtl/sn_block_loader_pad.sv
// ---------------------------------------------------------------------------
// sn_pad_mask
// Combinational helper for the block loader. Given the beat slot being
// written and whether this beat is flagged as the last one, produces:
//   keep : NB-bit thermometer mask, 1 = slot carries real data, 0 = pad it
//   cnt  : number of real records in the block being completed
// Ports:
//   idx   in   beat slot of the current accept
//   last  in   current beat ends the block
//   keep  out  per-slot keep mask
//   cnt   out  real-record count, meaningful when the beat completes a block
// ---------------------------------------------------------------------------
module sn_pad_mask
    import sn_block_loader_pkg::*;
#(
    parameter int P_LOG = SN_DEF_P_LOG,
    parameter int W_LOG = SN_DEF_W_LOG,
    localparam int NB   = 1 << (P_LOG - W_LOG),
    localparam int IDXW = sn_idx_w(P_LOG, W_LOG)
) (
    input  logic [IDXW-1:0] idx,
    input  logic            last,
    output logic [NB-1:0]   keep,
    output logic [P_LOG:0]  cnt
);

    // Without a flush every slot is real data. On a flush only slots up to and
    // including the current one are real; the rest become pads. The count is
    // beats-so-far times records-per-beat, which naturally equals the full
    // block size when the final slot completes the block.
    always_comb begin
        keep = '1;
        for (int s = 0; s < NB; s++) begin
            keep[s] = !last || (IDXW'(s) <= idx);
        end
        cnt = ((P_LOG + 1)'(idx) + (P_LOG + 1)'(1)) << W_LOG;
    end

endmodule

// File: rtl/sn_block_loader.sv
// ---------------------------------------------------------------------------
// sn_block_loader
// Upstream feeder for the even-odd merge sorting network. Gathers beats of
// 1<<W_LOG records into a block of 1<<P_LOG records and presents the block
// as a one-cycle DOT/DOTEN pulse. A short block ended with ILAST is padded
// with all-ones records so the pads sort to the tail.
// Ports:
//   CLK     in   clock
//   RST     in   synchronous active-high reset
//   IVALID  in   beat valid
//   IREADY  out  loader accepts a beat this cycle
//   IDATA   in   beat, record j at [DATW*(j+1)-1:DATW*j]
//   ILAST   in   beat ends the current block
//   DOT     out  assembled block, record i at [DATW*(i+1)-1:DATW*i]
//   DOTEN   out  one-cycle strobe, DOT holds a new block
//   OCNT    out  number of real (non-pad) records in DOT
// ---------------------------------------------------------------------------
module sn_block_loader
    import sn_block_loader_pkg::*;
#(
    parameter int P_LOG = SN_DEF_P_LOG,
    parameter int W_LOG = SN_DEF_W_LOG,
    parameter int DATW  = SN_DEF_DATW,
    parameter int KEYW  = SN_DEF_KEYW
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       IVALID,
    output logic                       IREADY,
    input  logic [(DATW<<W_LOG)-1:0]   IDATA,
    input  logic                       ILAST,
    output logic [(DATW<<P_LOG)-1:0]   DOT,
    output logic                       DOTEN,
    output logic [P_LOG:0]             OCNT
);

    localparam int NB   = 1 << (P_LOG - W_LOG);
    localparam int IDXW = sn_idx_w(P_LOG, W_LOG);
    localparam int BW   = DATW << W_LOG;

    // Pad record: maximum key in the low KEYW bits, payload bits also all ones.
    localparam logic [DATW-1:0] PAD_REC  = {DATW{1'b1}} | DATW'({KEYW{1'b1}});
    localparam logic [BW-1:0]   PAD_BEAT = {(1 << W_LOG){PAD_REC}};

    logic [0:0]          state_q;
    logic [IDXW-1:0]     idx_q;
    logic [BW-1:0]       buf_q [NB];
    logic                accept;
    logic                complete;
    logic [NB-1:0]       keep;
    logic [P_LOG:0]      cnt;
    logic [(DATW<<P_LOG)-1:0] dot_next;

    assign IREADY   = (state_q == SN_FILL);
    assign accept   = IVALID && IREADY;
    assign complete = accept && (ILAST || (idx_q == IDXW'(NB - 1)));

    sn_pad_mask #(
        .P_LOG (P_LOG),
        .W_LOG (W_LOG)
    ) u_pad_mask (
        .idx  (idx_q),
        .last (ILAST),
        .keep (keep),
        .cnt  (cnt)
    );

    // Merge mux: the beat being accepted lands directly in its slot, earlier
    // slots come from the fill buffer, and slots past a flush become pads so
    // leftovers from a previous block can never leak out.
    for (genvar s = 0; s < NB; s++) begin : g_slot
        assign dot_next[s*BW +: BW] = (idx_q == IDXW'(s)) ? IDATA :
                                      (keep[s] ? buf_q[s] : PAD_BEAT);
    end

    // Fill buffer: every accepted beat is parked in its slot. Contents are
    // don't-care after reset because stale slots are masked on a flush and
    // overwritten before use otherwise.
    always_ff @(posedge CLK) begin
        for (int s = 0; s < NB; s++) begin
            if (accept && (idx_q == IDXW'(s))) begin
                buf_q[s] <= IDATA;
            end
        end
    end

    // Control: ready comes up the cycle after reset drops, the beat counter
    // returns to slot 0 whenever a block completes, and the output register
    // only loads on completion so DOT is stable between strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SN_IDLE;
            idx_q   <= '0;
            DOT     <= '0;
            DOTEN   <= 1'b0;
            OCNT    <= '0;
        end else begin
            state_q <= SN_FILL;
            DOTEN   <= complete;
            if (accept) begin
                idx_q <= complete ? '0 : (idx_q + IDXW'(1));
            end
            if (complete) begin
                DOT  <= dot_next;
                OCNT <= cnt;
            end
        end
    end

endmodule
